// File: rtl/ntt_scheduler_if.sv
// Issue and write-back bundle between the NTT scheduler (master) and the butterfly datapath (slave).
// Lane l occupies [8l+:8] of the index buses and [7l+:7] of the zeta bus.
interface ntt_scheduler_if;
   logic        issue_valid;
   logic        issue_ready;
   logic [63:0] issue_a_idx;
   logic [63:0] issue_b_idx;
   logic [55:0] issue_zeta_idx;
   logic        rd_bank;
   logic        wb_valid;
   logic [63:0] wb_a_idx;
   logic [63:0] wb_b_idx;
   logic        wb_bank;

   modport master (
      output issue_valid, issue_a_idx, issue_b_idx, issue_zeta_idx, rd_bank,
      output wb_valid, wb_a_idx, wb_b_idx, wb_bank,
      input  issue_ready
   );

   modport slave (
      input  issue_valid, issue_a_idx, issue_b_idx, issue_zeta_idx, rd_bank,
      input  wb_valid, wb_a_idx, wb_b_idx, wb_bank,
      output issue_ready
   );
endinterface

// File: rtl/ntt_scheduler.sv
// Kyber forward-NTT sequencer: one 8-butterfly group per handshake, write-back BF_LATENCY cycles later.
// issue_ready low freezes the current group; each stage waits for its last write-back before the next.
module ntt_scheduler #(
   parameter int LANES      = 8,
   parameter int BF_LATENCY = 5,
   parameter int NUM_STAGES = 7
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   output logic            busy,
   output logic            done,
   output logic [2:0]      stage,
   ntt_scheduler_if.master bus
);
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

   typedef struct packed {
      logic        vld;
      logic [63:0] a;
      logic [63:0] b;
      logic        bank;
   } wb_ent_t;

   localparam logic [2:0] LAST_STAGE = 3'(NUM_STAGES - 1);
   localparam logic [3:0] LAST_GROUP = 4'(128 / LANES - 1);

   state_t      state_q, state_d;
   logic [2:0]  stage_q, stage_d;
   logic [3:0]  group_q, group_d;
   wb_ent_t     pipe_q [BF_LATENCY];
   wb_ent_t     ent_in;
   logic        fire;
   logic        in_flight;

   logic [63:0] a_bus, b_bus;
   logic [55:0] z_bus;
   logic [2:0]  sh;
   logic [3:0]  sh1;
   logic [7:0]  len8;
   logic [6:0]  p, blk;
   logic [7:0]  off, a_l;

   assign fire = (state_q == S_ISSUE) && bus.issue_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= S_IDLE;
         stage_q <= '0;
         group_q <= '0;
      end else begin
         state_q <= state_d;
         stage_q <= stage_d;
         group_q <= group_d;
      end
   end

   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      group_d = group_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               stage_d = '0;
               group_d = '0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            if (fire) begin
               group_d = group_q + 4'd1;
               if (group_q == LAST_GROUP) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            // Barrier: the next stage reads the bank this stage is still writing.
            if (!in_flight) begin
               if (stage_q == LAST_STAGE) begin
                  state_d = S_DONE;
               end else begin
                  stage_d = stage_q + 3'd1;
                  group_d = '0;
                  state_d = S_ISSUE;
               end
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // a inserts a zero bit at position log2(len) of the butterfly number p; b sets that bit.
   always_comb begin
      a_bus = '0;
      b_bus = '0;
      z_bus = '0;
      p     = '0;
      blk   = '0;
      off   = '0;
      a_l   = '0;
      sh    = 3'd7 - stage_q;
      sh1   = {1'b0, sh} + 4'd1;
      len8  = 8'd1 << sh;
      for (int l = 0; l < LANES; l++) begin
         p   = {group_q, 3'(l)};
         blk = p >> sh;
         off = {1'b0, p} & (len8 - 8'd1);
         a_l = ({1'b0, blk} << sh1) | off;
         a_bus[8*l +: 8] = a_l;
         b_bus[8*l +: 8] = a_l + len8;
         z_bus[7*l +: 7] = (7'd1 << stage_q) + blk;
      end
   end

   always_comb begin
      ent_in = '0;
      if (fire) begin
         ent_in.vld  = 1'b1;
         ent_in.a    = a_bus;
         ent_in.b    = b_bus;
         ent_in.bank = ~stage_q[0];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < BF_LATENCY; i++) pipe_q[i] <= '0;
      end else begin
         pipe_q[0] <= ent_in;
         for (int i = 1; i < BF_LATENCY; i++) pipe_q[i] <= pipe_q[i-1];
      end
   end

   always_comb begin
      in_flight = 1'b0;
      for (int i = 0; i < BF_LATENCY; i++) in_flight = in_flight | pipe_q[i].vld;
   end

   assign busy  = (state_q != S_IDLE);
   assign done  = (state_q == S_DONE);
   assign stage = stage_q;

   assign bus.issue_valid    = (state_q == S_ISSUE);
   assign bus.issue_a_idx    = (state_q == S_ISSUE) ? a_bus : '0;
   assign bus.issue_b_idx    = (state_q == S_ISSUE) ? b_bus : '0;
   assign bus.issue_zeta_idx = (state_q == S_ISSUE) ? z_bus : '0;
   assign bus.rd_bank        = stage_q[0];

   assign bus.wb_valid = pipe_q[BF_LATENCY-1].vld;
   assign bus.wb_a_idx = pipe_q[BF_LATENCY-1].a;
   assign bus.wb_b_idx = pipe_q[BF_LATENCY-1].b;
   assign bus.wb_bank  = pipe_q[BF_LATENCY-1].bank;
endmodule

// File: tb/tb_ntt_scheduler.sv
// Scoreboard bench for ntt_scheduler: expected groups come from the textbook Kyber NTT loop nest,
// a negedge monitor checks issues, write-back timing/indices, busy/done and per-stage coverage.
module tb_ntt_scheduler;
   localparam int LAT = 5;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       busy, done;
   logic [2:0] stage;

   ntt_scheduler_if bus_if ();

   ntt_scheduler #(.LANES(8), .BF_LATENCY(LAT), .NUM_STAGES(7)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .busy  (busy),
      .done  (done),
      .stage (stage),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int          stage;
      logic [63:0] a;
      logic [63:0] b;
      logic [55:0] z;
   } iss_t;

   typedef struct {
      int          due;
      int          stage;
      logic [63:0] a;
      logic [63:0] b;
      logic        bank;
   } wb_t;

   iss_t exp_iss[$];
   wb_t  exp_wb[$];

   int n_chk = 0;
   int n_err = 0;
   int t0 = 0;
   int exp_done_rel = 155;
   bit run_active = 0;
   bit abort_chk = 0;
   int wb_cnt, done_cnt, iss_n;
   int cov [7][256];

   task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (rel cycle %0d)", nm, act, exp, cyc - t0);
      end
   endtask

   function automatic logic [55:0] zrep(int lo, int hi);
      logic [55:0] r;
      r = '0;
      for (int l = 0; l < 8; l++) r[7*l +: 7] = (l < 4) ? 7'(lo) : 7'(hi);
      return r;
   endfunction

   // Reference: the Kyber NTT loop (len halves, k counts zetas), chopped into groups of 8 butterflies.
   task automatic build_expected();
      int   k, s, len;
      int   av[$], bv[$], zv[$];
      iss_t e;
      k = 1; s = 0; len = 128;
      while (len >= 2) begin
         av.delete(); bv.delete(); zv.delete();
         for (int st = 0; st < 256; st += 2 * len) begin
            for (int j = st; j < st + len; j++) begin
               av.push_back(j);
               bv.push_back(j + len);
               zv.push_back(k);
            end
            k++;
         end
         for (int g = 0; g < 16; g++) begin
            e.stage = s; e.a = '0; e.b = '0; e.z = '0;
            for (int l = 0; l < 8; l++) begin
               e.a[8*l +: 8] = 8'(av[8*g + l]);
               e.b[8*l +: 8] = 8'(bv[8*g + l]);
               e.z[7*l +: 7] = 7'(zv[8*g + l]);
            end
            exp_iss.push_back(e);
         end
         s++;
         len = len / 2;
      end
   endtask

   // Monitor / scoreboard
   initial forever begin
      int   rel;
      iss_t ei;
      wb_t  ew;
      @(negedge clk);
      rel = cyc - t0;
      if (run_active) begin
         chk("busy", busy, 64'(rel >= 1 && rel <= exp_done_rel));
         if (done) begin
            done_cnt++;
            chk("done_cycle", rel, exp_done_rel);
         end
         if (bus_if.issue_valid) begin
            if (exp_iss.size() == 0) begin
               chk("issue_unexpected", 1, 0);
            end else begin
               ei = exp_iss[0];
               chk("issue_a", bus_if.issue_a_idx, ei.a);
               chk("issue_b", bus_if.issue_b_idx, ei.b);
               chk("issue_zeta", bus_if.issue_zeta_idx, ei.z);
               chk("rd_bank", bus_if.rd_bank, 64'(ei.stage & 1));
               chk("stage", stage, ei.stage);
               if (bus_if.issue_ready) begin
                  void'(exp_iss.pop_front());
                  ew.due = cyc + LAT; ew.stage = ei.stage;
                  ew.a = ei.a; ew.b = ei.b; ew.bank = ~ei.stage[0];
                  exp_wb.push_back(ew);
                  if (iss_n == 0) begin
                     chk("first_a", bus_if.issue_a_idx, 64'h0706050403020100);
                     chk("first_b", bus_if.issue_b_idx, 64'h8786858483828180);
                     chk("first_zeta", bus_if.issue_zeta_idx, zrep(1, 1));
                  end
                  if (iss_n == 4*16 + 3) begin
                     chk("s4g3_a", bus_if.issue_a_idx, 64'h3736353433323130);
                     chk("s4g3_b", bus_if.issue_b_idx, 64'h3F3E3D3C3B3A3938);
                     chk("s4g3_zeta", bus_if.issue_zeta_idx, zrep(19, 19));
                  end
                  if (iss_n == 5*16) begin
                     chk("s5g0_a", bus_if.issue_a_idx, 64'h0B0A090803020100);
                     chk("s5g0_b", bus_if.issue_b_idx, 64'h0F0E0D0C07060504);
                     chk("s5g0_zeta", bus_if.issue_zeta_idx, zrep(32, 33));
                  end
                  if (iss_n == 6*16 + 15) begin
                     chk("s6g15_a0", bus_if.issue_a_idx[7:0], 240);
                     chk("s6g15_b0", bus_if.issue_b_idx[7:0], 242);
                     chk("s6g15_z0", bus_if.issue_zeta_idx[6:0], 124);
                     chk("s6g15_a7", bus_if.issue_a_idx[63:56], 253);
                     chk("s6g15_b7", bus_if.issue_b_idx[63:56], 255);
                     chk("s6g15_z7", bus_if.issue_zeta_idx[55:49], 127);
                  end
                  iss_n++;
               end
            end
         end
         if (bus_if.wb_valid) begin
            if (exp_wb.size() == 0) begin
               chk("wb_unexpected", 1, 0);
            end else begin
               ew = exp_wb.pop_front();
               chk("wb_cycle", cyc, ew.due);
               chk("wb_a", bus_if.wb_a_idx, ew.a);
               chk("wb_b", bus_if.wb_b_idx, ew.b);
               chk("wb_bank", bus_if.wb_bank, ew.bank);
               if (wb_cnt == 111) chk("last_wb_bank", bus_if.wb_bank, 1);
               for (int l = 0; l < 8; l++) begin
                  cov[ew.stage][ew.a[8*l +: 8]]++;
                  cov[ew.stage][ew.b[8*l +: 8]]++;
               end
            end
            wb_cnt++;
         end
      end
      if (abort_chk) begin
         chk("abort_busy", busy, 0);
         chk("abort_wb_valid", bus_if.wb_valid, 0);
      end
   end

   task automatic to_cycle(int r);
      while (cyc - t0 < r) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic start_run(int done_rel);
      exp_iss.delete();
      exp_wb.delete();
      build_expected();
      wb_cnt = 0; done_cnt = 0; iss_n = 0;
      for (int s = 0; s < 7; s++) for (int i = 0; i < 256; i++) cov[s][i] = 0;
      exp_done_rel = done_rel;
      t0 = cyc;
      start = 1'b1;
      run_active = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic finish_run();
      int bad;
      for (int i = 0; i < 600 && done_cnt == 0; i++) begin
         @(posedge clk); #1;
      end
      chk("done_seen", 64'(done_cnt > 0), 1);
      repeat (3) begin
         @(posedge clk); #1;
      end
      run_active = 1'b0;
      chk("done_pulses", done_cnt, 1);
      chk("wb_count", wb_cnt, 112);
      chk("issue_queue_empty", exp_iss.size(), 0);
      chk("wb_queue_empty", exp_wb.size(), 0);
      for (int s = 0; s < 7; s++) begin
         bad = 0;
         for (int i = 0; i < 256; i++) if (cov[s][i] != 1) bad++;
         chk($sformatf("stage%0d_coverage_bad", s), bad, 0);
      end
   endtask

   initial begin
      bus_if.issue_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_stage", stage, 0);
      chk("rst_issue_valid", bus_if.issue_valid, 0);
      chk("rst_issue_a", bus_if.issue_a_idx, 0);
      chk("rst_issue_b", bus_if.issue_b_idx, 0);
      chk("rst_issue_zeta", bus_if.issue_zeta_idx, 0);
      chk("rst_rd_bank", bus_if.rd_bank, 0);
      chk("rst_wb_valid", bus_if.wb_valid, 0);
      chk("rst_wb_a", bus_if.wb_a_idx, 0);
      chk("rst_wb_b", bus_if.wb_b_idx, 0);
      chk("rst_wb_bank", bus_if.wb_bank, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
      end

      // Nominal run with a start pulse while busy that must be ignored
      start_run(155);
      to_cycle(50);
      start = 1'b1;
      to_cycle(51);
      start = 1'b0;
      finish_run();

      // Three-cycle stall at stage 2 group 7
      start_run(158);
      to_cycle(52);
      bus_if.issue_ready = 1'b0;
      to_cycle(55);
      bus_if.issue_ready = 1'b1;
      finish_run();

      // Random ready stalls: done slips by exactly the number of stalled issue cycles
      begin
         int stalls;
         stalls = 0;
         start_run(1000);
         for (int i = 0; i < 400 && iss_n < 112; i++) begin
            bus_if.issue_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (bus_if.issue_valid && !bus_if.issue_ready) stalls++;
            @(posedge clk); #1;
         end
         bus_if.issue_ready = 1'b1;
         exp_done_rel = 155 + stalls;
         finish_run();
      end

      // Reset in the middle of stage 1
      start_run(155);
      to_cycle(40);
      reset = 1'b1;
      to_cycle(41);
      reset = 1'b0;
      run_active = 1'b0;
      exp_iss.delete();
      exp_wb.delete();
      abort_chk = 1'b1;
      repeat (12) begin
         @(posedge clk); #1;
      end
      abort_chk = 1'b0;

      // Fresh transform after the abort
      start_run(155);
      finish_run();

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/ntt_scheduler.md
Name: ntt_scheduler

Overview:
- Sequencer for the 8-lane Cooley-Tukey butterfly array used by the Kyber forward NTT (N=256, 7 stages, len = 128 >> stage).
- Per cycle it issues one group of 8 butterflies: coefficient indices and zeta-ROM indices for every lane.
- It tracks in-flight groups through the fixed-latency butterfly pipeline and emits matching write-back indices.
- It enforces a stage barrier, provides ping-pong bank select, and reports start/busy/done to the top-level Kyber control.

Parameters:
- LANES, 8, butterflies issued per group (fixed; 128/LANES = 16 groups per stage)
- BF_LATENCY, 5, cycles from an accepted issue to its write-back (min 1)
- NUM_STAGES, 7, NTT stages executed (stage 0..6)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  begin a transform; sampled only in IDLE
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse when the final stage has fully written back
- issue_valid  out  1  a butterfly group is presented
- issue_ready  in  1  datapath accepts the group; issue fires on valid&&ready
- issue_a_idx  out  64  lane l at [8l+:8], top-operand coefficient index
- issue_b_idx  out  64  lane l at [8l+:8], equals a_idx + len
- issue_zeta_idx  out  56  lane l at [7l+:7], zeta ROM index
- rd_bank  out  1  buffer bank read this stage (= stage[0])
- wb_valid  out  1  write-back group valid
- wb_a_idx  out  64  delayed copy of the issued a indices
- wb_b_idx  out  64  delayed copy of the issued b indices
- wb_bank  out  1  bank to write (= ~rd_bank of the issuing stage)
- stage  out  3  current stage number

Behaviour:
- Reset values: state=IDLE, stage=0, group=0, pipeline valid bits cleared. All outputs are 0: busy, done, issue_valid, wb_valid, index buses and banks.
- Reset mid-transform aborts immediately. The in-flight pipeline is flushed, and wb_valid is 0 from the next cycle onward.
- FSM IDLE -> ISSUE -> DRAIN -> (ISSUE | DONE) -> IDLE.
  - IDLE: start=1 sets stage=0, group=0, next state ISSUE. start while not IDLE is ignored.
  - ISSUE: issue_valid=1. On the handshake, group increments. The handshake on group 15 moves to DRAIN. While issue_ready=0, group and all issue buses hold stable.
  - DRAIN: issue_valid=0. When no entries are in flight: if stage==6 go to DONE, else stage+1, group=0, go to ISSUE.
  - DONE: done=1 for exactly one cycle, then IDLE.
- Index math, with p = group*8 + l (0..127), len = 128 >> stage, blk = p >> (7-stage), off = p & (len-1):
  - a = blk*2*len + off
  - b = a + len
  - zeta = (1 << stage) + blk
  - All values are unsigned, with no wrap (a, b ≤ 255; zeta ≤ 127).
- Pipeline: a BF_LATENCY-deep shift register of {valid, a, b, bank}. A handshake at cycle T produces wb_valid at T+BF_LATENCY with identical indices. A non-handshake cycle inserts a bubble.
- Stage barrier: no stage s+1 issue occurs before the last stage-s write-back. This guarantees the ping-pong buffers never read and write the same bank.
- Timing with ready held at 1 and BF_LATENCY=5 (start seen at cycle 0):
  - Issues occur at cycles 1..16 and write-backs at cycles 6..21.
  - Stage 1 issues start at cycle 23, giving a stage period of 16 + BF_LATENCY + 1 = 22 cycles.
  - The last write-back is at cycle 153, done=1 at cycle 155, and busy falls at cycle 156.
- Each cycle of issue_ready=0 during ISSUE delays done by exactly one cycle.

Test Plan:
- Reset, then start with ready=1 -> first issue at cycle 1:
  - lane l has a=l, b=l+128, zeta=1, rd_bank=0.
  - done pulses once at cycle 155; exactly 112 wb_valid cycles total; busy high for cycles 1..155.
- Stage 4, group 3 -> a=48..55, b=56..63, all zeta=19. Stage 5, group 0:
  - lanes 0-3: a=0..3, b=4..7, zeta=32.
  - lanes 4-7: a=8..11, b=12..15, zeta=33.
- Stage 6, group 15 -> lane0 a=240, b=242, zeta=124; lane7 a=253, b=255, zeta=127; wb_bank=1.
- Drop ready for 3 cycles at stage 2, group 7:
  - issue buses stay frozen during the stall.
  - the write-back stream shows a 3-cycle gap.
  - done arrives at cycle 158.
- Assert reset at cycle 40 (stage 1 in flight) -> next cycle busy=0 and wb_valid=0 with no further write-backs. A fresh start then reproduces the cycle-1 values.
- Pulse start at cycle 50 while busy -> ignored; done still occurs at cycle 155. Scoreboard check: every (a,b) pair is written exactly once per stage.
